// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the multicycle datapath.
// Optional bne support is enabled by defining BNE_EN.

module multicycle_control (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic [5:0] iOpcode,
  input  logic [5:0] iFunct,
  input  logic       iZero,
  output logic       oPCEn,
  output logic       oIorD,
  output logic       oMemRead,
  output logic       oMemWrite,
  output logic       oIRWrite,
  output logic       oRegDst,
  output logic       oMemtoReg,
  output logic       oRegWrite,
  output logic       oALUSrcA,
  output logic [1:0] oALUSrcB,
  output logic [3:0] oALUControl,
  output logic [1:0] oPCSource,
  output logic       oIllegal,
  output logic [3:0] oState
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEXEC = 4'd6,
    RTWB   = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JUMP  = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t state;
  state_t nextState;
  logic   functOk;
  logic [3:0] functAlu;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= FETCH;
    else         state <= nextState;
  end

  always_comb begin
    functOk  = 1'b1;
    functAlu = ALU_AND;
    case (iFunct)
      6'b100000: functAlu = ALU_ADD;
      6'b100010: functAlu = ALU_SUB;
      6'b100100: functAlu = ALU_AND;
      6'b100101: functAlu = ALU_OR;
      6'b101010: functAlu = ALU_SLT;
      default:   functOk  = 1'b0;
    endcase
  end

  assign oState = state;

  // Outputs are gated by iRST_n so nothing strobes while reset is held.
  always_comb begin
    nextState   = FETCH;
    oPCEn       = 1'b0;
    oIorD       = 1'b0;
    oMemRead    = 1'b0;
    oMemWrite   = 1'b0;
    oIRWrite    = 1'b0;
    oRegDst     = 1'b0;
    oMemtoReg   = 1'b0;
    oRegWrite   = 1'b0;
    oALUSrcA    = 1'b0;
    oALUSrcB    = 2'b00;
    oALUControl = ALU_AND;
    oPCSource   = 2'b00;
    oIllegal    = 1'b0;
    if (iRST_n) begin
      case (state)
        FETCH: begin
          oMemRead    = 1'b1;
          oIRWrite    = 1'b1;
          oALUSrcB    = 2'b01;
          oALUControl = ALU_ADD;
          oPCEn       = 1'b1;
          nextState   = DECODE;
        end
        DECODE: begin
          oALUSrcB    = 2'b11;
          oALUControl = ALU_ADD;
          case (iOpcode)
            OP_RTYPE: begin
              if (functOk) nextState = RTEXEC;
              else         oIllegal  = 1'b1;
            end
            OP_LW, OP_SW: nextState = MEMADR;
            OP_BEQ:       nextState = BRANCH;
`ifdef BNE_EN
            OP_BNE:       nextState = BRANCH;
`endif
            OP_JUMP:      nextState = JUMP;
            OP_ADDI:      nextState = ADDIEX;
            default:      oIllegal  = 1'b1;
          endcase
        end
        MEMADR: begin
          oALUSrcA    = 1'b1;
          oALUSrcB    = 2'b10;
          oALUControl = ALU_ADD;
          nextState   = (iOpcode == OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: begin
          oIorD     = 1'b1;
          oMemRead  = 1'b1;
          nextState = MEMWB;
        end
        MEMWB: begin
          oMemtoReg = 1'b1;
          oRegWrite = 1'b1;
        end
        MEMWR: begin
          oIorD     = 1'b1;
          oMemWrite = 1'b1;
        end
        RTEXEC: begin
          oALUSrcA    = 1'b1;
          oALUControl = functAlu;
          nextState   = RTWB;
        end
        RTWB: begin
          oRegDst   = 1'b1;
          oRegWrite = 1'b1;
        end
        BRANCH: begin
          oALUSrcA    = 1'b1;
          oALUControl = ALU_SUB;
          oPCSource   = 2'b01;
`ifdef BNE_EN
          oPCEn       = (iOpcode == OP_BNE) ? ~iZero : iZero;
`else
          oPCEn       = iZero;
`endif
        end
        JUMP: begin
          oPCSource = 2'b10;
          oPCEn     = 1'b1;
        end
        ADDIEX: begin
          oALUSrcA    = 1'b1;
          oALUSrcB    = 2'b10;
          oALUControl = ALU_ADD;
          nextState   = ADDIWB;
        end
        ADDIWB: begin
          oRegWrite = 1'b1;
        end
        default: nextState = FETCH;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control FSM for the multicycle datapath. It is the initiator side of the ALU interface: it issues the 4-bit ALU operation code and datapath steering signals each cycle, and consumes the ALU zero flag to resolve branches. It sits between the instruction register (opcode/funct fields) and the shared ALU, register file, PC and unified memory.

## Interface

Parameters: none.

Ports:
- iCLK  in  1  system clock, rising edge
- iRST_n  in  1  asynchronous reset, active-low
- iOpcode  in  6  instruction[31:26] from IR
- iFunct  in  6  instruction[5:0] from IR
- iZero  in  1  ALU zero flag
- oPCEn  out  1  PC write enable (unconditional or branch-taken)
- oIorD  out  1  memory address: 0=PC, 1=ALUOut
- oMemRead / oMemWrite  out  1 each  memory strobes
- oIRWrite  out  1  IR load
- oRegDst  out  1  write register: 0=rt, 1=rd
- oMemtoReg  out  1  writeback data: 0=ALUOut, 1=MDR
- oRegWrite  out  1  register file write
- oALUSrcA  out  1  0=PC, 1=A
- oALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- oALUControl  out  4  0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt
- oPCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- oIllegal  out  1  one-cycle flag: undecodable instruction
- oState  out  4  current state (debug)

## Operation

- State register 4 bits: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, RTWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12–15 go to FETCH next cycle, all outputs 0.
- Outputs are decoded from state only, except oPCEn in BRANCH and oALUControl in RTEXEC. Unlisted outputs are 0.
- FETCH: MemRead, IRWrite, SrcA=0, SrcB=01, add, PCSource=00, PCEn=1 -> DECODE.
- DECODE: SrcA=0, SrcB=11, add (branch target into ALUOut). Next state by opcode:
  - 000000 -> RTEXEC
  - 100011/101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - else -> FETCH with oIllegal=1.
  - An R-type with funct outside {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt} is also illegal.
- MEMADR: SrcA=1, SrcB=10, add -> MEMRD (lw) or MEMWR (sw).
- MEMRD: IorD=1, MemRead -> MEMWB. MEMWB: MemtoReg=1, RegDst=0, RegWrite -> FETCH.
- MEMWR: IorD=1, MemWrite -> FETCH.
- RTEXEC: SrcA=1, SrcB=00, oALUControl mapped from iFunct -> RTWB. RTWB: RegDst=1, RegWrite -> FETCH.
- BRANCH: SrcA=1, SrcB=00, sub, PCSource=01, oPCEn=iZero (beq) -> FETCH.
- JUMP: PCSource=10, PCEn=1 -> FETCH.
- ADDIEX: SrcA=1, SrcB=10, add -> ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite -> FETCH.

## Timing

- Cycles per instruction, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2.
- While iRST_n=0: state=FETCH and every output is forced to 0, including oPCEn, oIRWrite and oMemRead. oState reads 0.
- First rising edge after reset release: FETCH outputs are active.
- Reset asserted mid-instruction: takes effect immediately; no write strobe stays high. Partial instructions are abandoned.
- iZero→oPCEn is a combinational path, valid only in BRANCH. iOpcode and iFunct must stay stable from DECODE through the instruction's last state; the IR is written only in FETCH, so this holds.
- oIllegal is high only during the DECODE cycle of an undecodable instruction.

## Configuration

- BNE_EN defined: opcode 000101 decodes to BRANCH with oPCEn=~iZero. All other BRANCH outputs are unchanged.
- BNE_EN undefined: opcode 000101 is illegal (oIllegal pulse, return to FETCH).

## Test plan

- Reset held low 3 cycles mid-MEMRD, then released -> all outputs 0 during reset; oState=0 and oPCEn=1 on the first cycle after release.
- lw (100011) -> oState sequence 0,1,2,3,4,0. MEMRD has oIorD=1; MEMWB has oRegWrite=1 and oMemtoReg=1.
- R-type with funct 101010, then 100010 -> RTEXEC oALUControl=0111, then 0110. RTWB has oRegDst=1.
- beq with iZero=1, then with iZero=0 -> BRANCH oPCEn=1 and oPCSource=01; then oPCEn=0. 3 cycles each.
- opcode 000101 -> with BNE_EN and iZero=0, oPCEn=1; without BNE_EN, oIllegal=1 in DECODE and next state=FETCH.
- opcode 111111, and R-type with funct 000111 -> oIllegal one cycle; no oRegWrite or oMemWrite; 2-cycle return to FETCH.
